// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to its consumers.
// The timing source drives it through the master modport; consumers read it through slave.
interface vga_timing_gen_if;
  logic        pix_en;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        hSync;
  logic        vSync;
  logic        bright;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    output pix_en, hCount, vCount, hSync, vSync, bright, line_start, frame_start, frame_count
  );

  modport slave (
    input pix_en, hCount, vCount, hSync, vSync, bright, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: divides the system clock to the pixel rate and produces counters,
// syncs, the visible-area flag and line/frame pulses, all registered and mutually aligned.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_VIS_START = 144,
  parameter int unsigned H_VIS_END   = 784,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_VIS_START = 35,
  parameter int unsigned V_VIS_END   = 515
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master tim_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      hcount_q, hcount_d;
  logic [9:0]      vcount_q, vcount_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic            pix_en_q, pix_en_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            bright_q, bright_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;
  logic            advance;

  always_comb begin
    advance       = (div_q == DivW'(CLK_DIV - 1));
    div_d         = advance ? '0 : div_q + DivW'(1);
    pix_en_d      = advance;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_count_d = frame_count_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (advance) begin
      if (hcount_q == 10'(H_TOTAL - 1)) begin
        hcount_d     = '0;
        line_start_d = 1'b1;
        if (vcount_q == 10'(V_TOTAL - 1)) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end

    // Decode from next-state counters so the registered flags line up with the counters.
    // Compare at 32 bits so a region end of 1024 still works with 10-bit counters.
    hsync_d  = 32'(hcount_d) >= H_SYNC;
    vsync_d  = 32'(vcount_d) >= V_SYNC;
    bright_d = (32'(hcount_d) >= H_VIS_START) && (32'(hcount_d) < H_VIS_END) &&
               (32'(vcount_d) >= V_VIS_START) && (32'(vcount_d) < V_VIS_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_count_q <= '0;
      pix_en_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      bright_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_count_q <= frame_count_d;
      pix_en_q      <= pix_en_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      bright_q      <= bright_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign tim_o.pix_en      = pix_en_q;
  assign tim_o.hCount      = hcount_q;
  assign tim_o.vCount      = vcount_q;
  assign tim_o.hSync       = hsync_q;
  assign tim_o.vSync       = vsync_q;
  assign tim_o.bright      = bright_q;
  assign tim_o.line_start  = line_start_q;
  assign tim_o.frame_start = frame_start_q;
  assign tim_o.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds (default 640x480, a small CLK_DIV=3 raster, a tiny
// CLK_DIV=1 raster) checked every clock against a model derived from elapsed clocks since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    int unsigned div;
    int unsigned ht;
    int unsigned hsy;
    int unsigned hvs;
    int unsigned hve;
    int unsigned vt;
    int unsigned vsy;
    int unsigned vvs;
    int unsigned vve;
  } cfg_t;

  typedef struct packed {
    logic        pix_en;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        br;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  localparam cfg_t CfgA = '{div: 4, ht: 800, hsy: 96, hvs: 144, hve: 784,
                            vt: 525, vsy: 2, vvs: 35, vve: 515};
  localparam cfg_t CfgB = '{div: 3, ht: 20, hsy: 3, hvs: 5, hve: 17,
                            vt: 12, vsy: 2, vvs: 3, vve: 10};
  localparam cfg_t CfgC = '{div: 1, ht: 8, hsy: 1, hvs: 2, hve: 7,
                            vt: 5, vsy: 1, vvs: 2, vve: 4};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if vif_a ();
  vga_timing_gen_if vif_b ();
  vga_timing_gen_if vif_c ();

  vga_timing_gen dut_a (
    .clk   (clk),
    .reset (reset),
    .tim_o (vif_a)
  );

  vga_timing_gen #(
    .CLK_DIV     (3),
    .H_TOTAL     (20),
    .H_SYNC      (3),
    .H_VIS_START (5),
    .H_VIS_END   (17),
    .V_TOTAL     (12),
    .V_SYNC      (2),
    .V_VIS_START (3),
    .V_VIS_END   (10)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .tim_o (vif_b)
  );

  vga_timing_gen #(
    .CLK_DIV     (1),
    .H_TOTAL     (8),
    .H_SYNC      (1),
    .H_VIS_START (2),
    .H_VIS_END   (7),
    .V_TOTAL     (5),
    .V_SYNC      (1),
    .V_VIS_START (2),
    .V_VIS_END   (4)
  ) dut_c (
    .clk   (clk),
    .reset (reset),
    .tim_o (vif_c)
  );

  // Expected outputs after e clocks out of reset: n = e/div pixel advances have happened.
  function automatic exp_t model(input longint unsigned e, input cfg_t c);
    exp_t m;
    longint unsigned n, line;
    n        = e / 64'(c.div);
    line     = n / 64'(c.ht);
    m.pix_en = (e != 0) && ((e % 64'(c.div)) == 0);
    m.h      = 10'(n % 64'(c.ht));
    m.v      = 10'(line % 64'(c.vt));
    m.fc     = 16'(line / 64'(c.vt));
    m.hs     = 32'(m.h) >= c.hsy;
    m.vs     = 32'(m.v) >= c.vsy;
    m.br     = (32'(m.h) >= c.hvs) && (32'(m.h) < c.hve) &&
               (32'(m.v) >= c.vvs) && (32'(m.v) < c.vve);
    m.ls     = m.pix_en && (m.h == 10'd0);
    m.fs     = m.ls && (m.v == 10'd0);
    return m;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t observe_a();
    return '{pix_en: vif_a.pix_en, h: vif_a.hCount, v: vif_a.vCount, hs: vif_a.hSync,
             vs: vif_a.vSync, br: vif_a.bright, ls: vif_a.line_start,
             fs: vif_a.frame_start, fc: vif_a.frame_count};
  endfunction

  function automatic exp_t observe_b();
    return '{pix_en: vif_b.pix_en, h: vif_b.hCount, v: vif_b.vCount, hs: vif_b.hSync,
             vs: vif_b.vSync, br: vif_b.bright, ls: vif_b.line_start,
             fs: vif_b.frame_start, fc: vif_b.frame_count};
  endfunction

  function automatic exp_t observe_c();
    return '{pix_en: vif_c.pix_en, h: vif_c.hCount, v: vif_c.vCount, hs: vif_c.hSync,
             vs: vif_c.vSync, br: vif_c.bright, ls: vif_c.line_start,
             fs: vif_c.frame_start, fc: vif_c.frame_count};
  endfunction

  longint unsigned e = 0;
  bit              valid = 1'b0;
  int unsigned     rst_left = 0;

  // Drive reset for the next edge, then compare all three builds 1 ns after that edge.
  task automatic step(input logic rst_v);
    @(negedge clk);
    reset = rst_v;
    @(posedge clk);
    #1;
    if (rst_v) begin
      e     = 0;
      valid = 1'b1;
    end else begin
      e++;
    end
    if (valid) begin
      check($sformatf("a e=%0d", e), 64'(observe_a()), 64'(model(e, CfgA)));
      check($sformatf("b e=%0d", e), 64'(observe_b()), 64'(model(e, CfgB)));
      check($sformatf("c e=%0d", e), 64'(observe_c()), 64'(model(e, CfgC)));
    end
  endtask

  initial begin
    repeat (2) step(1'b1);
    // Long clean run: several lines of the default raster, many frames of the small ones.
    repeat (8000) step(1'b0);
    // Single-clock reset in the middle of a line/frame.
    step(1'b1);
    repeat (2500) step(1'b0);
    // Random run with occasional short reset pulses at random raster positions.
    for (int i = 0; i < 30000; i++) begin
      if (rst_left == 0 && $urandom_range(0, 2999) == 0) rst_left = $urandom_range(1, 3);
      if (rst_left != 0) begin
        rst_left--;
        step(1'b1);
      end else begin
        step(1'b0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
